reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports Clk (rising edge active) and Rst_n.
REQ-002 Clk  input  1  system clock; all state updates on rising edge; the downstream register file writes on the falling edge.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 AReq  input  1  requester A (ALU write-back) has a pending write; held high until granted.
REQ-005 AAddr / AData  input  5 / 32  requester A destination register and write data; stable while AReq=1.
REQ-006 AGnt  output  1  combinational grant to A; the write is accepted at the rising edge where AGnt=1.
REQ-007 BReq, BAddr, BData, BGnt  in/in/in/out  1/5/32/1  requester B (load write-back), same rules as A.
REQ-008 Hold  input  1  pipeline freeze; no grants while high.
REQ-009 ChkAddr  input  5  read address probed for a write-back hazard.
REQ-010 ChkHit  output  1  combinational; 1 when the output stage holds a valid write to ChkAddr and ChkAddr!=0.
REQ-011 RegWrite / RegWrAddr / RegWrData  output  1/5/32  registered write port driving the register file.
REQ-012 WrCount  output  16  number of committed register writes, saturating.

Function
REQ-013 Grants SHALL be one-hot or zero; a grant is asserted only to a requester whose Req=1, and only when Hold=0 and Rst_n=1.
REQ-014 If exactly one requester is active, it SHALL be granted in the same cycle.
REQ-015 If both are active, the requester named by the 1-bit round-robin pointer Prio (0=A, 1=B) SHALL be granted; the other waits.
REQ-016 Prio SHALL update only on a grant, to point to the requester not granted in that cycle; otherwise it holds.
REQ-017 On a granted edge, the output stage SHALL load RegWrAddr/RegWrData from the granted requester and set RegWrite=1 if the address is nonzero, else RegWrite=0 (the write to r0 is accepted and discarded).
REQ-018 On an edge with no grant, RegWrite SHALL go to 0; RegWrAddr/RegWrData hold their previous values.
REQ-019 Latency from grant edge to RegWrite=1 SHALL be zero cycles of wait: RegWrite is high in the cycle immediately after the grant edge, for exactly one cycle per grant.
REQ-020 Back-to-back grants SHALL be allowed every cycle; the sustained throughput is one write per cycle.
REQ-021 When both requesters target the same address in consecutive grants, both writes SHALL be issued in grant order; the later one wins in the register file.
REQ-022 ChkHit SHALL compare against RegWrAddr only while RegWrite=1.
REQ-023 WrCount SHALL increment by 1 on each edge that loads RegWrite=1 and saturate at 16'hFFFF.
REQ-024 Hold asserted mid-stream SHALL block new grants from the next evaluation; a write already loaded still completes its single RegWrite cycle.
REQ-025 A requester that drops Req without a grant SHALL be ignored, with no state change.

Reset
REQ-026 While Rst_n=0, regardless of Clk: RegWrite=0, RegWrAddr=0, RegWrData=0, WrCount=0, Prio=0 (A), AGnt=BGnt=0, ChkHit=0.
REQ-027 An assertion of Rst_n in the cycle after a grant SHALL cancel the pending RegWrite pulse; no write is issued.
REQ-028 The first grant after Rst_n deasserts SHALL follow REQ-014/015 with Prio=A.

Verification
REQ-029 Reset, then AReq=1, AAddr=5, AData=32'h1234 for one cycle -> AGnt=1 that cycle; next cycle RegWrite=1, RegWrAddr=5, RegWrData=32'h1234; WrCount=1.
REQ-030 AReq=BReq=1 held for 4 cycles from reset (A:addr 3, B:addr 4) -> grant sequence A,B,A,B; RegWrAddr sequence 3,4,3,4 with RegWrite high continuously.
REQ-031 BReq=1, BAddr=0, BData=32'hFFFF_FFFF -> BGnt=1; next cycle RegWrite=0, WrCount unchanged, ChkHit=0 with ChkAddr=0.
REQ-032 Hold=1 with AReq=1 for 3 cycles, then Hold=0 -> AGnt=0 for 3 cycles, then AGnt=1; one RegWrite pulse follows.
REQ-033 A granted at addr 7, ChkAddr=7 -> ChkHit=1 during the RegWrite cycle only; Rst_n pulsed low in that cycle -> RegWrite, ChkHit drop to 0 immediately.
REQ-034 Preload WrCount near saturation by forcing 65540 single-requester grants -> WrCount stops at 16'hFFFF.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: merges two write-back requesters (ALU and load) into a
// single registered register-file write port, using round-robin priority
// when both requesters collide. It also provides a hazard probe on the
// in-flight write.
module reg_wb_arbiter (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        AReq,
    input  logic [4:0]  AAddr,
    input  logic [31:0] AData,
    output logic        AGnt,
    input  logic        BReq,
    input  logic [4:0]  BAddr,
    input  logic [31:0] BData,
    output logic        BGnt,
    input  logic        Hold,
    input  logic [4:0]  ChkAddr,
    output logic        ChkHit,
    output logic        RegWrite,
    output logic [4:0]  RegWrAddr,
    output logic [31:0] RegWrData,
    output logic [15:0] WrCount
);

    // prio_q: 0 favours A, 1 favours B; only consulted when both request
    logic        prio_q, prio_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  reg_wr_addr_q, reg_wr_addr_d;
    logic [31:0] reg_wr_data_q, reg_wr_data_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        a_gnt, b_gnt;

    // Grant decode: one-hot or zero; gated by reset and Hold so nothing is
    // accepted while the pipeline is frozen or the block is in reset
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (Rst_n && !Hold) begin
            if (AReq && BReq) begin
                if (prio_q) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else if (AReq) begin
                a_gnt = 1'b1;
            end else if (BReq) begin
                b_gnt = 1'b1;
            end
        end
    end

    // Next-state: load the output stage from the winner; r0 writes are
    // accepted but produce no RegWrite pulse
    always_comb begin
        prio_d        = prio_q;
        reg_write_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        wr_count_d    = wr_count_q;
        if (a_gnt) begin
            reg_wr_addr_d = AAddr;
            reg_wr_data_d = AData;
            reg_write_d   = (AAddr != 5'd0);
            prio_d        = 1'b1;
        end else if (b_gnt) begin
            reg_wr_addr_d = BAddr;
            reg_wr_data_d = BData;
            reg_write_d   = (BAddr != 5'd0);
            prio_d        = 1'b0;
        end
        if (reg_write_d && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // State registers; async reset also cancels any pending write pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_q        <= 1'b0;
            reg_write_q   <= 1'b0;
            reg_wr_addr_q <= 5'd0;
            reg_wr_data_q <= 32'd0;
            wr_count_q    <= 16'd0;
        end else begin
            prio_q        <= prio_d;
            reg_write_q   <= reg_write_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            wr_count_q    <= wr_count_d;
        end
    end

    assign AGnt      = a_gnt;
    assign BGnt      = b_gnt;
    assign RegWrite  = reg_write_q;
    assign RegWrAddr = reg_wr_addr_q;
    assign RegWrData = reg_wr_data_q;
    assign WrCount   = wr_count_q;
    // Hazard only while a real write is in flight; r0 never hazards
    assign ChkHit    = reg_write_q && (ChkAddr == reg_wr_addr_q) && (ChkAddr != 5'd0);

endmodule
